pe_apb_master: RTL and testbench

- APB3 initiator that turns a simple valid/ready command into one APB transfer.
- Returns read data and error status on a valid/ready response channel.
- Drives the PE register slave (or any APB3 target) from the host-side controller and the bring-up sequencer.
- Handles one transfer at a time: command accepted, SETUP, ACCESS with wait states, response.

---
 rtl/pe_apb_master.sv | 124 ++++++++++++
 tb/tb_pe_apb_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_apb_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer, answered on a valid/ready response.
// Optional ACCESS-phase timeout is enabled by defining PE_APB_MASTER_TIMEOUT_EN.
module pe_apb_master #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state_reg;

    generate
        if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYC must be in 2..65535");
        end
    endgenerate

`ifdef PE_APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
`ifdef PE_APB_MASTER_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        pwrite    <= cmd_write;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    penable   <= 1'b1;
                    state_reg <= ACCESS;
`ifdef PE_APB_MASTER_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        // Read data is meaningless on a write, so the response carries zero.
                        rsp_rdata   <= pwrite ? 32'd0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state_reg   <= RESP;
                    end else begin
`ifdef PE_APB_MASTER_TIMEOUT_EN
                        if (tmo_cnt_reg == TMO_LIMIT) begin
                            rsp_rdata   <= 32'd0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            state_reg   <= RESP;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                        end
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_apb_master.sv
// Self-checking bench for pe_apb_master: directed scenarios plus randomized transfers
// checked against a per-transaction expectation model (phase lengths and response payload).
module tb_pe_apb_master;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err, rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata, prdata;
    logic              pwrite, psel, penable, pready, pslverr;

    int errors = 0;
    int checks = 0;

    pe_apb_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transfer; expectations come from the transaction description alone.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic se, input int rdly);
        logic [31:0] exp_rd;
        exp_rd = w ? 32'd0 : rd;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_psel", psel, 0);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
        step();
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_paddr", paddr, a);
        pready = $urandom; pslverr = $urandom; prdata = $urandom;
        step();
        for (int k = 0; k <= waits; k++) begin
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, a);
            chk("access_pwdata", pwdata, wd);
            chk("access_pwrite", pwrite, w);
            chk("access_rsp_valid", rsp_valid, 0);
            pready  = (k == waits);
            prdata  = (k == waits) ? rd : $urandom;
            pslverr = (k == waits) ? se : $urandom;
            step();
        end
        pready = 0; pslverr = 0; prdata = $urandom;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_psel_low", psel, 0);
        chk("rsp_penable_low", penable, 0);
        for (int d = 0; d <= rdly; d++) begin
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", rsp_err, se);
            chk("rsp_timeout", rsp_timeout, 0);
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_cmd_ready", cmd_ready, 0);
            rsp_ready = (d == rdly);
            step();
        end
        rsp_ready = 0;
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_cmd_ready", cmd_ready, 1);
        $display("xfer w=%0d addr=0x%02h wd=0x%08h waits=%0d rd=0x%08h err=%0d hold=%0d",
                 w, a, wd, waits, rd, se, rdly);
    endtask

    initial begin
        int cnt;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 0; prdata = '0; pready = 0; pslverr = 0;
        step(); step();
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_rsp_timeout", rsp_timeout, 0);
        rst = 0;
        rsp_ready = 1;
        step();
        chk("spurious_rsp_ready", rsp_valid, 0);
        rsp_ready = 0;

        // Directed: zero-wait write, 3-wait read, slave error held 5 cycles.
        xfer(1'b1, 8'h20, 32'hDEADBEEF, 0, 32'hFFFF_FFFF, 1'b0, 0);
        xfer(1'b0, 8'h04, 32'h0, 3, 32'h12345678, 1'b0, 0);
        xfer(1'b0, 8'h3C, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 5);
        xfer(1'b1, 8'h10, 32'h0BADF00D, 1, 32'h0, 1'b1, 1);

        // Back-to-back with cmd_valid held high.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h44; cmd_wdata = 0;
        step();
        cmd_addr = 8'h48;
        chk("b2b_first_paddr", paddr, 8'h44);
        pready = 1; prdata = 32'h11112222;
        step(); step();
        pready = 0;
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_busy_paddr", paddr, 8'h44);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("b2b_gap_psel", psel, 0);
        chk("b2b_gap_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 0;
        chk("b2b_second_psel", psel, 1);
        chk("b2b_second_paddr", paddr, 8'h48);
        pready = 1; prdata = 32'h33334444;
        step(); step();
        pready = 0;
        chk("b2b_second_rdata", rsp_rdata, 32'h33334444);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Reset during an ACCESS wait state.
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h55; cmd_wdata = 32'h5555;
        step();
        cmd_valid = 0;
        step(); step();
        chk("pre_rst_penable", penable, 1);
        rst = 1;
        step();
        rst = 0;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_paddr", paddr, 0);
        pready = 1;
        step(); step();
        pready = 0;
        chk("rst_no_rsp", rsp_valid, 0);

        // Timeout behaviour with pready stuck low.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h77; cmd_wdata = 0;
        step();
        cmd_valid = 0;
        step();
        cnt = 0;
        while (penable && cnt < 120) begin
            cnt++;
            step();
        end
`ifdef PE_APB_MASTER_TIMEOUT_EN
        chk("tmo_access_cycles", cnt, 8);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_timeout", rsp_timeout, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        chk("tmo_psel", psel, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
`else
        chk("no_tmo_still_access", cnt, 120);
        chk("no_tmo_rsp_valid", rsp_valid, 0);
        rst = 1;
        step();
        rst = 0;
`endif
        chk("tmo_after_cmd_ready", cmd_ready, 1);

        // Randomized transfers with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            xfer($urandom_range(0, 1), 8'($urandom), $urandom, $urandom_range(0, 5),
                 $urandom, $urandom_range(0, 1), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
